// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with variable step, parallel load, wrap-or-saturate
// bounds, a wrap pulse and sticky overflow/underflow flags. Optional wrap counter: UDC_WRAP_COUNT_EN.
module updown_counter_mod #(
    parameter int WIDTH       = 8,
    parameter int MAX_COUNT   = 2**WIDTH - 1,
    parameter int RESET_VALUE = 0,
    parameter int STEP_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              saturate,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              wrap_pulse,
    output logic              overflow_sticky,
    output logic              underflow_sticky
`ifdef UDC_WRAP_COUNT_EN
    ,
    output logic [7:0]        wrap_count
`endif
);

    // Wide enough that count+step and count+MAX_COUNT+1 never truncate.
    localparam int EXT_W = WIDTH + STEP_W + 1;

    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX_COUNT);
    localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MAX_COUNT + 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VALUE);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be >= 2");
    end
    if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
        $error("updown_counter_mod: MAX_COUNT must be in 1..2**WIDTH-1");
    end
    if (RESET_VALUE < 0 || RESET_VALUE > MAX_COUNT) begin : g_bad_reset
        $error("updown_counter_mod: RESET_VALUE must be in 0..MAX_COUNT");
    end
    if (2**STEP_W - 1 > MAX_COUNT + 1) begin : g_bad_step
        $error("updown_counter_mod: 2**STEP_W-1 must not exceed MAX_COUNT+1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [EXT_W-1:0] count_ext, step_ext, load_ext, sum_ext;

    assign count_ext = EXT_W'(count_q);
    assign step_ext  = EXT_W'(step);
    assign load_ext  = EXT_W'(load_value);
    assign sum_ext   = count_ext + step_ext;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q & ~clear_flags;
        unf_d   = unf_q & ~clear_flags;

        if (load) begin
            count_d = (load_ext > MAX_EXT) ? MAX_W : load_value;
        end else if (enable && step != '0) begin
            if (up_down) begin
                if (sum_ext > MAX_EXT) begin
                    ovf_d = 1'b1;
                    if (saturate) begin
                        count_d = MAX_W;
                    end else begin
                        count_d = WIDTH'(sum_ext - MOD_EXT);
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = WIDTH'(sum_ext);
                end
            end else begin
                if (count_ext < step_ext) begin
                    unf_d = 1'b1;
                    if (saturate) begin
                        count_d = '0;
                    end else begin
                        count_d = WIDTH'(count_ext + MOD_EXT - step_ext);
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = WIDTH'(count_ext - step_ext);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            count_q <= RST_W;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count            = count_q;
    assign at_max           = (count_q == MAX_W);
    assign at_min           = (count_q == '0);
    assign wrap_pulse       = wrap_q;
    assign overflow_sticky  = ovf_q;
    assign underflow_sticky = unf_q;

`ifdef UDC_WRAP_COUNT_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // A clear coinciding with a wrap restarts the tally at one.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clear_flags) begin
            wrap_cnt_d = wrap_d ? 8'd1 : 8'd0;
        end else if (wrap_d && wrap_cnt_q != 8'hFF) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt_q <= 8'd0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_count = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod at WIDTH=8, MAX_COUNT=9, STEP_W=3.
// Vector table for single-edge behaviour plus hand-written multi-cycle sequences.
module tb_updown_counter_mod;

    localparam int WIDTH     = 8;
    localparam int MAX_COUNT = 9;
    localparam int STEP_W    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic              saturate;
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic              clear_flags;
    logic [WIDTH-1:0]  count;
    logic              at_max;
    logic              at_min;
    logic              wrap_pulse;
    logic              overflow_sticky;
    logic              underflow_sticky;
`ifdef UDC_WRAP_COUNT_EN
    logic [7:0]        wrap_count;
    int                exp_wrap_count = 0;
`endif

    int errors = 0;
    int checks = 0;

    updown_counter_mod #(
        .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .RESET_VALUE(0), .STEP_W(STEP_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .step(step),
        .saturate(saturate), .load(load), .load_value(load_value), .clear_flags(clear_flags),
        .count(count), .at_max(at_max), .at_min(at_min), .wrap_pulse(wrap_pulse),
        .overflow_sticky(overflow_sticky), .underflow_sticky(underflow_sticky)
`ifdef UDC_WRAP_COUNT_EN
        , .wrap_count(wrap_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst; bit en; bit up; int stp; bit sat; bit ld; int lv; bit clr;
        int ec; bit ew; bit eo; bit eu;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input bit rst, input bit en, input bit up, input int stp,
                                input bit sat, input bit ld, input int lv, input bit clr,
                                input int ec, input bit ew, input bit eo, input bit eu);
        vec_t v;
        v.rst = rst; v.en = en; v.up = up; v.stp = stp; v.sat = sat; v.ld = ld;
        v.lv = lv; v.clr = clr; v.ec = ec; v.ew = ew; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset       = v.rst;
        enable      = v.en;
        up_down     = v.up;
        step        = STEP_W'(v.stp);
        saturate    = v.sat;
        load        = v.ld;
        load_value  = WIDTH'(v.lv);
        clear_flags = v.clr;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int ec, input bit ew, input bit eo, input bit eu);
        check({tag, " count"}, int'(count), ec);
        check({tag, " wrap_pulse"}, int'(wrap_pulse), int'(ew));
        check({tag, " overflow_sticky"}, int'(overflow_sticky), int'(eo));
        check({tag, " underflow_sticky"}, int'(underflow_sticky), int'(eu));
        check({tag, " at_max"}, int'(at_max), (ec == MAX_COUNT) ? 1 : 0);
        check({tag, " at_min"}, int'(at_min), (ec == 0) ? 1 : 0);
    endtask

`ifdef UDC_WRAP_COUNT_EN
    task automatic track_wrap_count(input bit rst, input bit clr, input bit ew, input string tag);
        if (rst) exp_wrap_count = 0;
        else if (clr) exp_wrap_count = ew ? 1 : 0;
        else if (ew && exp_wrap_count < 255) exp_wrap_count++;
        check({tag, " wrap_count"}, int'(wrap_count), exp_wrap_count);
    endtask
`endif

    initial begin
        int wraps;

        // Vectors start from count=0, overflow=1, underflow=0 after the ten-step wrap sequence.
        //          rst en up stp sat ld lv  clr  ec ew eo eu
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   0,  0, 0, 1, 0)); // hold keeps sticky flag
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1,  0, 0, 0, 0)); // clear alone
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 8,   0,  8, 0, 0, 0)); // load 8
        vecs.push_back(mk(0, 1, 1, 3, 1, 0, 0,   0,  9, 0, 1, 0)); // 8+3 clamps to 9
        vecs.push_back(mk(0, 1, 1, 3, 1, 0, 0,   0,  9, 0, 1, 0)); // stays at 9
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1,  9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2,   0,  2, 0, 0, 0)); // load 2
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, 0,   0,  7, 1, 0, 1)); // 2+10-5
        vecs.push_back(mk(0, 0, 0, 5, 0, 0, 0,   0,  7, 0, 0, 1)); // pulse lasts one cycle
        vecs.push_back(mk(0, 1, 0, 7, 1, 0, 0,   0,  0, 0, 0, 1)); // 7-7 exact, no crossing
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0,   0,  0, 0, 0, 1)); // at 0 clamp
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0,   0,  0, 0, 0, 1)); // outward at bound sets flag
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 9,   1,  9, 0, 0, 0)); // load 9 with clear
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,   1,  0, 1, 1, 0)); // set beats clear
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1,  0, 0, 0, 0)); // clear alone
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,   0,  9, 1, 0, 1)); // down wrap
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,   0,  0, 1, 1, 1)); // back-to-back wrap
        vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0,   0,  7, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0,   0,  4, 1, 1, 1)); // 14-10
        vecs.push_back(mk(0, 1, 0, 6, 0, 0, 0,   0,  8, 1, 1, 1)); // 4+10-6
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,   0,  8, 0, 1, 1)); // step 0 holds
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,   1,  8, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 0, 1, 200, 0,  9, 0, 0, 0)); // load clamps, enable ignored
        vecs.push_back(mk(0, 1, 0, 7, 0, 1, 5,   0,  5, 0, 0, 0)); // load beats down wrap
        vecs.push_back(mk(0, 0, 1, 3, 0, 0, 0,   0,  5, 0, 0, 0)); // enable low holds
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 10,  0,  9, 0, 0, 0)); // load just above bound
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,   0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 5,   0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 1, 0, 0,   0,  9, 0, 1, 0)); // 12 clamps to 9
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,   0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 5,   0,  5, 0, 1, 0)); // count 5, flag set
        vecs.push_back(mk(1, 1, 1, 7, 0, 1, 3,   0,  0, 0, 0, 0)); // reset overrides all
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0,   0,  3, 0, 0, 0));

        // Reset state
        drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step_clk();
        step_clk();
        check_state("reset", 0, 0, 0, 0);
`ifdef UDC_WRAP_COUNT_EN
        track_wrap_count(1'b1, 1'b0, 1'b0, "reset");
`endif

        // Ten up-steps of 1 from 0: 1..9 then wrap to 0 with a single pulse
        wraps = 0;
        for (int i = 0; i < 10; i++) begin
            drive(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
            step_clk();
            check($sformatf("up1 step%0d count", i), int'(count), (i + 1) % 10);
            check($sformatf("up1 step%0d at_max", i), int'(at_max), (i == 8) ? 1 : 0);
            if (wrap_pulse) wraps++;
`ifdef UDC_WRAP_COUNT_EN
            track_wrap_count(1'b0, 1'b0, (i == 9), $sformatf("up1 step%0d", i));
`endif
        end
        check("up1 wrap pulses", wraps, 1);
        check("up1 overflow_sticky", int'(overflow_sticky), 1);
        check("up1 underflow_sticky", int'(underflow_sticky), 0);

        foreach (vecs[k]) begin
            drive(vecs[k]);
            step_clk();
            check_state($sformatf("vec%0d", k), vecs[k].ec, vecs[k].ew, vecs[k].eo, vecs[k].eu);
`ifdef UDC_WRAP_COUNT_EN
            track_wrap_count(vecs[k].rst, vecs[k].clr, vecs[k].ew, $sformatf("vec%0d", k));
`endif
        end

        // Sustained saturating climb: count pinned at 9 while the flag holds for several cycles
        drive(mk(0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        step_clk();
        check("climb first count", int'(count), 8);
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check($sformatf("climb hold%0d count", i), int'(count), 9);
            check($sformatf("climb hold%0d overflow", i), int'(overflow_sticky), 1);
            check($sformatf("climb hold%0d wrap_pulse", i), int'(wrap_pulse), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
